// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: line geometry, beat index and line types,
// and the serializer state encoding.
package cc_pkg;

    localparam int unsigned CC_BEAT_W     = 64;
    localparam int unsigned CC_LINE_BEATS = 8;
    localparam int unsigned CC_LINE_W     = CC_BEAT_W * CC_LINE_BEATS;

    typedef logic [$clog2(CC_LINE_BEATS)-1:0] cc_beat_idx_t;
    typedef logic [CC_LINE_W-1:0]             cc_line_t;

    typedef enum logic {
        IDLE,
        BURST
    } cc_ser_state_t;

endpackage

// File: rtl/cc_line_serializer_if.sv
// Line-request and R-burst signals of the line serializer.
// The master drives line requests and rready; the slave is the serializer.
interface cc_line_serializer_if #(
    parameter int unsigned BEAT_W     = 64,
    parameter int unsigned LINE_BEATS = 8,
    parameter int unsigned ID_W       = 4
);
    localparam int unsigned OFF_W = $clog2(LINE_BEATS);

    logic                         line_valid;
    logic                         line_ready;
    logic [BEAT_W*LINE_BEATS-1:0] line_data;
    logic [OFF_W-1:0]             line_offset;
    logic [ID_W-1:0]              line_id;

    logic [ID_W-1:0]              inct_rid;
    logic [BEAT_W-1:0]            inct_rdata;
    logic                         inct_rvalid;
    logic                         inct_rlast;
    logic                         inct_rready;

    modport master (
        output line_valid, line_data, line_offset, line_id, inct_rready,
        input  line_ready, inct_rid, inct_rdata, inct_rvalid, inct_rlast
    );

    modport slave (
        input  line_valid, line_data, line_offset, line_id, inct_rready,
        output line_ready, inct_rid, inct_rdata, inct_rvalid, inct_rlast
    );

endinterface

// File: rtl/cc_line_serializer.sv
// Serializes a cache line into a critical-word-first, wrapping R burst.
// Define CC_LINE_SERIALIZER_SKID_EN for a one-entry staging slot (back-to-back bursts).
module cc_line_serializer
    import cc_pkg::*;
#(
    parameter int unsigned BEAT_W     = CC_BEAT_W,
    parameter int unsigned LINE_BEATS = CC_LINE_BEATS,
    parameter int unsigned ID_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cc_line_serializer_if.slave   bus
);

    localparam int unsigned      OFF_W    = $clog2(LINE_BEATS);
    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_BEATS - 1);

    typedef logic [LINE_BEATS-1:0][BEAT_W-1:0] line_arr_t;

    cc_ser_state_t    state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [ID_W-1:0]  id_q, id_d;
    line_arr_t        line_q, line_d;

    logic             line_ready;
    logic             accept;
    logic             rvalid;
    logic             rlast;
    logic             beat_hs;
    logic             last_hs;
    logic [OFF_W-1:0] ptr;

`ifdef CC_LINE_SERIALIZER_SKID_EN
    logic             slot_full_q, slot_full_d;
    line_arr_t        slot_line_q, slot_line_d;
    logic [OFF_W-1:0] slot_off_q, slot_off_d;
    logic [ID_W-1:0]  slot_id_q, slot_id_d;

    assign line_ready = ~slot_full_q;
`else
    assign line_ready = (state_q == IDLE);
`endif

    assign accept  = bus.line_valid & line_ready;
    assign rvalid  = (state_q == BURST);
    assign rlast   = rvalid & (cnt_q == LAST_CNT);
    assign beat_hs = rvalid & bus.inct_rready;
    assign last_hs = beat_hs & rlast;

    // Modulo-LINE_BEATS wrap comes from truncation to OFF_W bits.
    assign ptr = off_q + cnt_q;

    assign bus.line_ready  = line_ready;
    assign bus.inct_rvalid = rvalid;
    assign bus.inct_rlast  = rlast;
    assign bus.inct_rdata  = line_q[ptr];
    assign bus.inct_rid    = id_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        off_d   = off_q;
        id_d    = id_q;
`ifdef CC_LINE_SERIALIZER_SKID_EN
        slot_full_d = slot_full_q;
        slot_line_d = slot_line_q;
        slot_off_d  = slot_off_q;
        slot_id_d   = slot_id_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    line_d  = line_arr_t'(bus.line_data);
                    off_d   = bus.line_offset;
                    id_d    = bus.line_id;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (last_hs) begin
                    cnt_d = '0;
`ifdef CC_LINE_SERIALIZER_SKID_EN
                    if (slot_full_q) begin
                        line_d      = slot_line_q;
                        off_d       = slot_off_q;
                        id_d        = slot_id_q;
                        slot_full_d = 1'b0;
                    end else if (accept) begin
                        // Line arriving on the final beat skips the empty slot.
                        line_d = line_arr_t'(bus.line_data);
                        off_d  = bus.line_offset;
                        id_d   = bus.line_id;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else if (beat_hs) begin
                    cnt_d = cnt_q + 1'b1;
                end
`ifdef CC_LINE_SERIALIZER_SKID_EN
                if (accept && !last_hs) begin
                    slot_line_d = line_arr_t'(bus.line_data);
                    slot_off_d  = bus.line_offset;
                    slot_id_d   = bus.line_id;
                    slot_full_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            off_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            off_q   <= off_d;
            id_q    <= id_d;
        end
    end

`ifdef CC_LINE_SERIALIZER_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full_q <= 1'b0;
            slot_line_q <= '0;
            slot_off_q  <= '0;
            slot_id_q   <= '0;
        end else begin
            slot_full_q <= slot_full_d;
            slot_line_q <= slot_line_d;
            slot_off_q  <= slot_off_d;
            slot_id_q   <= slot_id_d;
        end
    end
`endif

endmodule

// File: tb/tb_cc_line_serializer.sv
// Scoreboard bench for cc_line_serializer: expected beat order is computed per accepted
// line and checked by an independent monitor, together with timing and hold rules.
module tb_cc_line_serializer;
    import cc_pkg::*;

    localparam int BW = 64;
    localparam int LB = 8;
    localparam int IW = 4;
`ifdef CC_LINE_SERIALIZER_SKID_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    typedef struct packed {
        logic [BW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rr_mode  = 0;
    int hs_count = 0;
    int b2b_arm  = 0;

    beat_t exp_q[$];
    int    acc_q[$];

    cc_line_serializer_if #(.BEAT_W(BW), .LINE_BEATS(LB), .ID_W(IW)) bus ();

    cc_line_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BW*LB-1:0] pat_line();
        logic [BW*LB-1:0] l;
        for (int k = 0; k < LB; k++) l[k*BW +: BW] = 64'h0000_0000_0000_00A0 + 64'(k);
        return l;
    endfunction

    function automatic logic [BW*LB-1:0] rand_line();
        logic [BW*LB-1:0] l;
        for (int k = 0; k < LB * BW / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // Reference model: each accepted line expands into its wrapped beat sequence.
    always @(negedge clk) begin
        if (rst_n && bus.line_valid && bus.line_ready) begin
            for (int k = 0; k < LB; k++) begin
                int    idx;
                beat_t e;
                idx    = (int'(bus.line_offset) + k) % LB;
                e.data = bus.line_data[idx*BW +: BW];
                e.last = (k == LB - 1);
                e.id   = bus.line_id;
                exp_q.push_back(e);
            end
            acc_q.push_back(cyc);
        end
    end

    // Monitor
    logic  prev_stall;
    beat_t prev_beat;
    logic  in_burst;
    int    last_hs_cyc;

    always @(negedge clk) begin
        beat_t cur;
        cur = {bus.inct_rdata, bus.inct_rlast, bus.inct_rid};
        if (!rst_n) begin
            prev_stall  = 1'b0;
            in_burst    = 1'b0;
            last_hs_cyc = -100;
        end else begin
            if (!bus.inct_rvalid) chk("ready_idle", 128'(bus.line_ready), 128'(1));
`ifndef CC_LINE_SERIALIZER_SKID_EN
            else chk("ready_burst", 128'(bus.line_ready), 128'(0));
`endif
            if (prev_stall) begin
                chk("hold_valid", 128'(bus.inct_rvalid), 128'(1));
                chk("hold_beat", 128'(cur), 128'(prev_beat));
            end
            if (bus.inct_rvalid && !in_burst) begin
                in_burst = 1'b1;
                if (acc_q.size() == 0) begin
                    chk("burst_without_line", 128'(0), 128'(1));
                end else begin
                    int a, e;
                    a = acc_q.pop_front();
                    e = (a + 1 > last_hs_cyc + 1) ? a + 1 : last_hs_cyc + 1;
                    chk("first_beat_cycle", 128'(cyc), 128'(e));
                end
                if (b2b_arm == 1) chk("burst_gap", 128'(cyc - last_hs_cyc), 128'(GAP));
                if (b2b_arm > 0) b2b_arm--;
            end
            if (bus.inct_rvalid && bus.inct_rready) begin
                hs_count++;
                if (exp_q.size() == 0) chk("unexpected_beat", 128'(cur), 128'(0));
                else chk("beat", 128'(cur), 128'(exp_q.pop_front()));
                if (bus.inct_rlast) begin
                    in_burst    = 1'b0;
                    last_hs_cyc = cyc;
                end
            end
            prev_stall = bus.inct_rvalid & ~bus.inct_rready;
            prev_beat  = cur;
        end
    end

    // rready: 0 = always 1, 1 = random, 2 = repeating 1,0,0
    initial begin
        int ph;
        ph = 0;
        bus.inct_rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                1:       bus.inct_rready = 1'($urandom_range(0, 1));
                2: begin
                    bus.inct_rready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                default: bus.inct_rready = 1'b1;
            endcase
        end
    end

    task automatic send_line(input logic [BW*LB-1:0] d, input logic [2:0] off,
                             input logic [IW-1:0] id);
        int n;
        n = 0;
        bus.line_valid  = 1'b1;
        bus.line_data   = d;
        bus.line_offset = off;
        bus.line_id     = id;
        @(negedge clk);
        while (!bus.line_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        bus.line_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.inct_rvalid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        bus.line_valid  = 1'b0;
        bus.line_data   = '0;
        bus.line_offset = '0;
        bus.line_id     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 128'(bus.inct_rvalid), 128'(0));
        chk("rst_rlast", 128'(bus.inct_rlast), 128'(0));
        chk("rst_rdata", 128'(bus.inct_rdata), 128'(0));
        chk("rst_rid", 128'(bus.inct_rid), 128'(0));
        chk("rst_ready", 128'(bus.line_ready), 128'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Offset 0 and offset 5 with rready high.
        send_line(pat_line(), 3'd0, 4'h3);
        drain();
        send_line(pat_line(), 3'd5, 4'hA);
        drain();

        // rready pattern 1,0,0: each beat held across stalls, exactly 8 handshakes.
        rr_mode = 2;
        base = hs_count;
        send_line(pat_line(), 3'd6, 4'h9);
        drain();
        chk("stall_hs_count", 128'(hs_count - base), 128'(LB));
        chk("stall_back_idle", 128'(bus.line_ready), 128'(1));
        rr_mode = 0;

        // Second line presented during a burst; offset 7 wraps 7,0..6.
        send_line(pat_line(), 3'd0, 4'h3);
        b2b_arm = 2;
        send_line(rand_line(), 3'd7, 4'h5);
        drain();

        // Randomized lines, offsets, IDs and rready.
        rr_mode = 1;
        for (int i = 0; i < 25; i++) begin
            send_line(rand_line(), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        drain();
        rr_mode = 0;

        // Reset after the third beat discards the burst.
        base = hs_count;
        send_line(pat_line(), 3'd3, 4'h2);
        n = 0;
        while (hs_count < base + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        chk("pre_reset_valid", 128'(bus.inct_rvalid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 128'(bus.inct_rvalid), 128'(0));
        chk("mid_rst_rlast", 128'(bus.inct_rlast), 128'(0));
        chk("mid_rst_rdata", 128'(bus.inct_rdata), 128'(0));
        chk("mid_rst_ready", 128'(bus.line_ready), 128'(1));
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_ready", 128'(bus.line_ready), 128'(1));
        send_line(pat_line(), 3'd2, 4'h1);
        drain();
        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
